// File: rtl/mem_port_pkg.sv
// Shared types for the CPU-to-RAM port sequencer: FSM state encoding,
// RAM read/write pin levels and the kind of request currently in flight.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR_ADDR = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    REQ_FETCH,
    REQ_LOAD,
    REQ_STORE
  } req_kind_t;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// CPU request/ack bus and RAM pin bundle for mem_port_ctrl.
// The master side is the CPU core plus RAM; the slave side is the sequencer.
interface mem_port_ctrl_if #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
);
    logic                    fetch_req;
    logic [ADDRESS_SIZE-1:0] fetch_addr;
    logic                    fetch_ack;
    logic [DATA_SIZE-1:0]    instr_out;
    logic                    ls_req;
    logic                    ls_write;
    logic [ADDRESS_SIZE-1:0] ls_addr;
    logic [DATA_SIZE-1:0]    ls_wdata;
    logic                    ls_ack;
    logic [DATA_SIZE-1:0]    ls_rdata;
    logic [ADDRESS_SIZE-1:0] ram_address;
    logic                    ram_read_write;
    logic [DATA_SIZE-1:0]    ram_data_in;
    logic [DATA_SIZE-1:0]    ram_data_out;
    logic                    busy;

    modport master (
        output fetch_req, fetch_addr, ls_req, ls_write, ls_addr, ls_wdata, ram_data_out,
        input  fetch_ack, instr_out, ls_ack, ls_rdata, ram_address, ram_read_write,
               ram_data_in, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, ls_req, ls_write, ls_addr, ls_wdata, ram_data_out,
        output fetch_ack, instr_out, ls_ack, ls_rdata, ram_address, ram_read_write,
               ram_data_in, busy
    );
endinterface

// File: rtl/mem_port_perf.sv
// Saturating activity counters for mem_port_ctrl.
// Only exists when MEM_PORT_PERF_COUNT_EN is defined.
`ifdef MEM_PORT_PERF_COUNT_EN
module mem_port_perf #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              fetch_ack,
    input  logic              load_ack,
    input  logic              store_ack,
    output logic [PERF_W-1:0] perf_fetches,
    output logic [PERF_W-1:0] perf_loads,
    output logic [PERF_W-1:0] perf_stores,
    output logic [PERF_W-1:0] perf_fetch_stall
);

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetches     <= '0;
            perf_loads       <= '0;
            perf_stores      <= '0;
            perf_fetch_stall <= '0;
        end else begin
            if (fetch_ack)              perf_fetches     <= sat_inc(perf_fetches);
            if (load_ack)               perf_loads       <= sat_inc(perf_loads);
            if (store_ack)              perf_stores      <= sat_inc(perf_stores);
            if (fetch_req && !fetch_ack) perf_fetch_stall <= sat_inc(perf_fetch_stall);
        end
    end

endmodule
`endif

// File: rtl/mem_port_ctrl.sv
// Sequencer arbitrating instruction fetches and LDR/STR onto a single-port word RAM.
// Optional counter bank enabled by MEM_PORT_PERF_COUNT_EN.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
`ifdef MEM_PORT_PERF_COUNT_EN
    ,
    parameter int PERF_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_ctrl_if.slave    bus
`ifdef MEM_PORT_PERF_COUNT_EN
    ,
    output logic [PERF_W-1:0] perf_fetches,
    output logic [PERF_W-1:0] perf_loads,
    output logic [PERF_W-1:0] perf_stores,
    output logic [PERF_W-1:0] perf_fetch_stall
`endif
);

    state_t               state;
    req_kind_t            kind;
    logic [DATA_SIZE-1:0] wdata_q;

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            kind               <= REQ_FETCH;
            wdata_q            <= '0;
            bus.fetch_ack      <= 1'b0;
            bus.ls_ack         <= 1'b0;
            bus.instr_out      <= '0;
            bus.ls_rdata       <= '0;
            bus.ram_address    <= '0;
            bus.ram_read_write <= RW_READ;
            bus.ram_data_in    <= '0;
        end else begin
            bus.fetch_ack <= 1'b0;
            bus.ls_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    // Loads/stores win over fetches; a still-high fetch_req is taken next IDLE.
                    if (bus.ls_req) begin
                        bus.ram_address <= bus.ls_addr;
                        wdata_q         <= bus.ls_wdata;
                        if (bus.ls_write) begin
                            kind               <= REQ_STORE;
                            bus.ram_read_write <= RW_WRITE;
                            bus.ram_data_in    <= ~bus.ls_wdata;
                            state              <= WR_ADDR;
                        end else begin
                            kind  <= REQ_LOAD;
                            state <= RD;
                        end
                    end else if (bus.fetch_req) begin
                        bus.ram_address <= bus.fetch_addr;
                        kind            <= REQ_FETCH;
                        state           <= RD;
                    end
                end
                RD: begin
                    if (kind == REQ_FETCH) begin
                        bus.instr_out <= bus.ram_data_out;
                        bus.fetch_ack <= 1'b1;
                    end else begin
                        bus.ls_rdata <= bus.ram_data_out;
                        bus.ls_ack   <= 1'b1;
                    end
                    state <= IDLE;
                end
                WR_ADDR: begin
                    // data_in was ~wdata, so this change is guaranteed to be a RAM write event.
                    bus.ram_data_in <= wdata_q;
                    state           <= WR_DATA;
                end
                WR_DATA: begin
                    bus.ram_read_write <= RW_READ;
                    bus.ls_ack         <= 1'b1;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PORT_PERF_COUNT_EN
    mem_port_perf #(.PERF_W(PERF_W)) u_perf (
        .clk              (clk),
        .reset            (reset),
        .fetch_req        (bus.fetch_req),
        .fetch_ack        (bus.fetch_ack),
        .load_ack         (bus.ls_ack && (kind == REQ_LOAD)),
        .store_ack        (bus.ls_ack && (kind == REQ_STORE)),
        .perf_fetches     (perf_fetches),
        .perf_loads       (perf_loads),
        .perf_stores      (perf_stores),
        .perf_fetch_stall (perf_fetch_stall)
    );
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural word RAM
// (combinational read, write on a data_in change while read_write is low).
module tb_mem_port_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] mem [0:65535];
    logic [31:0] prev_din;

    mem_port_ctrl_if #(.DATA_SIZE(32), .ADDRESS_SIZE(16)) bus ();

`ifdef MEM_PORT_PERF_COUNT_EN
    logic [31:0] perf_fetches, perf_loads, perf_stores, perf_fetch_stall;
`endif

    mem_port_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_PORT_PERF_COUNT_EN
        ,
        .perf_fetches     (perf_fetches),
        .perf_loads       (perf_loads),
        .perf_stores      (perf_stores),
        .perf_fetch_stall (perf_fetch_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_data_out = mem[bus.ram_address];

    // RAM write model: any data_in change seen mid-cycle while read_write is low
    always @(negedge clk) begin
        if (bus.ram_data_in !== prev_din && bus.ram_read_write == 1'b0)
            mem[bus.ram_address] = bus.ram_data_in;
        prev_din = bus.ram_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] a, output logic [31:0] instr, output int lat);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        lat   = 0;
        instr = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (bus.fetch_ack) begin
                instr = bus.instr_out;
                break;
            end
        end
        bus.fetch_req = 1'b0;
    endtask

    task automatic do_ls(input logic wr, input logic [15:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
        bus.ls_req   = 1'b1;
        bus.ls_write = wr;
        bus.ls_addr  = a;
        bus.ls_wdata = d;
        lat = 0;
        rd  = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (bus.ls_ack) begin
                rd = bus.ls_rdata;
                break;
            end
        end
        bus.ls_req   = 1'b0;
        bus.ls_write = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          cyc, ls_cyc, f_cyc;
        logic [31:0] ls_val, f_val;

        checks   = 0;
        failures = 0;
        prev_din = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0004] = 32'hE3A01005;
        mem[16'h0010] = 32'hCAFEF00D;
        mem[16'hFFFF] = 32'h0BADC0DE;

        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.ls_req     = 1'b0;
        bus.ls_write   = 1'b0;
        bus.ls_addr    = '0;
        bus.ls_wdata   = '0;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_rw",    {31'd0, bus.ram_read_write}, 32'd1);
        chk("rst_din",   bus.ram_data_in, 32'd0);
        chk("rst_addr",  {16'd0, bus.ram_address}, 32'd0);
        reset = 1'b0;
        tick();

        // Fetch, plus a fetch from the top word
        do_fetch(16'h0004, rd, lat);
        chk("fetch_lat",   lat, 2);
        chk("fetch_instr", rd, 32'hE3A01005);
        do_fetch(16'hFFFF, rd, lat);
        chk("fetch_top",   rd, 32'h0BADC0DE);

        // Store then load back
        do_ls(1'b1, 16'h0100, 32'h12345678, rd, lat);
        chk("str_lat",  lat, 3);
        chk("str_mem",  mem[16'h0100], 32'h12345678);
        chk("str_rw_back", {31'd0, bus.ram_read_write}, 32'd1);
        do_ls(1'b0, 16'h0100, 32'h0, rd, lat);
        chk("ldr_lat",  lat, 2);
        chk("ldr_data", rd, 32'h12345678);

        // Repeated identical data must still reach the RAM
        do_ls(1'b1, 16'h0200, 32'h00000000, rd, lat);
        chk("str_zero", mem[16'h0200], 32'h0);
        do_ls(1'b1, 16'h0200, 32'hAAAA5555, rd, lat);
        do_ls(1'b1, 16'h0200, 32'hAAAA5555, rd, lat);
        chk("str_twice", mem[16'h0200], 32'hAAAA5555);
        do_ls(1'b1, 16'h0201, 32'hAAAA5555, rd, lat);
        chk("str_same_new_addr", mem[16'h0201], 32'hAAAA5555);

        // Reset in the middle of a store
        bus.ls_req   = 1'b1;
        bus.ls_write = 1'b1;
        bus.ls_addr  = 16'h0300;
        bus.ls_wdata = 32'h00000001;
        tick();
        chk("wr_addr_busy", {31'd0, bus.busy}, 32'd1);
        chk("wr_addr_rw",   {31'd0, bus.ram_read_write}, 32'd0);
        chk("wr_addr_din",  bus.ram_data_in, 32'hFFFFFFFE);
        reset = 1'b1;
        bus.ls_req   = 1'b0;
        bus.ls_write = 1'b0;
        tick();
        chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_rw",    {31'd0, bus.ram_read_write}, 32'd1);
        chk("mid_rst_din",   bus.ram_data_in, 32'd0);
        chk("mid_rst_addr",  {16'd0, bus.ram_address}, 32'd0);
        chk("mid_rst_instr", bus.instr_out, 32'd0);
        chk("mid_rst_rdata", bus.ls_rdata, 32'd0);
        chk("mid_rst_acks",  {30'd0, bus.fetch_ack, bus.ls_ack}, 32'd0);
        reset = 1'b0;
        tick();

        // Simultaneous fetch and load, counted from a clean reset
        pulse_reset();
        tick();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h0004;
        bus.ls_req     = 1'b1;
        bus.ls_write   = 1'b0;
        bus.ls_addr    = 16'h0010;
        cyc = 0; ls_cyc = 0; f_cyc = 0;
        ls_val = '0; f_val = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cyc++;
            chk("ack_overlap", {31'd0, bus.fetch_ack & bus.ls_ack}, 32'd0);
            if (bus.ls_ack) begin
                ls_cyc = cyc;
                ls_val = bus.ls_rdata;
                bus.ls_req = 1'b0;
            end
            if (bus.fetch_ack) begin
                f_cyc = cyc;
                f_val = bus.instr_out;
                bus.fetch_req = 1'b0;
                break;
            end
        end
        bus.ls_req    = 1'b0;
        bus.fetch_req = 1'b0;
        chk("arb_ls_cyc",    ls_cyc, 2);
        chk("arb_fetch_cyc", f_cyc, 4);
        chk("arb_ls_data",   ls_val, 32'hCAFEF00D);
        chk("arb_instr",     f_val, 32'hE3A01005);
        tick();
`ifdef MEM_PORT_PERF_COUNT_EN
        chk("perf_loads",   perf_loads, 32'd1);
        chk("perf_fetches", perf_fetches, 32'd1);
        chk("perf_stores",  perf_stores, 32'd0);
        chk("perf_stall",   perf_fetch_stall, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
